// File: rtl/as_mul_c_if.sv
// as_mul_c_if: request/result bundle for the as_mul_c fixed-point add/sub/multiply unit.
//   start        request pulse, accepted only while busy is low
//   control_sig  [1] 1 = add/sub, 0 = multiply; [0] 1 = subtract (add/sub only)
//   a, b         signed Q(PART_LEN).(PART_LEN) operands
//   res, ovf     registered result and overflow flag of the last completed operation
//   busy         high while a multiply is iterating
//   done         one-cycle pulse marking res/ovf as freshly updated
// Modports: master drives the request side, slave is the arithmetic unit.
interface as_mul_c_if #(
    parameter int unsigned PART_LEN = 8
);
    logic                    start;
    logic [1:0]              control_sig;
    logic [2*PART_LEN-1:0]   a;
    logic [2*PART_LEN-1:0]   b;
    logic [2*PART_LEN-1:0]   res;
    logic                    busy;
    logic                    done;
    logic                    ovf;

    modport master (
        output start, control_sig, a, b,
        input  res, busy, done, ovf
    );

    modport slave (
        input  start, control_sig, a, b,
        output res, busy, done, ovf
    );
endinterface

// File: rtl/as_mul_c.sv
// as_mul_c: signed fixed-point adder/subtractor and sequential shift-add multiplier.
// Operands and result are two's-complement Q(PART_LEN).(PART_LEN), 2*PART_LEN bits wide.
// Add/sub completes in one cycle; multiply iterates one multiplier bit per cycle on
// operand magnitudes (2*PART_LEN cycles busy) and then applies the sign.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; aborts any multiply in flight
//   bus  as_mul_c_if.slave: start, control_sig, a, b in; res, busy, done, ovf out
// Build option: define AS_MUL_SATURATE_EN to clamp overflowed results to the signed
// extremes instead of wrapping to the low 2*PART_LEN bits (ovf asserts either way).
module as_mul_c #(
    parameter int unsigned PART_LEN = 8
) (
    input  logic       clk,
    input  logic       rst,
    as_mul_c_if.slave  bus
);
    localparam int unsigned W    = 2 * PART_LEN;
    localparam int unsigned PW   = 4 * PART_LEN;
    localparam int unsigned CntW = $clog2(W);

    localparam logic [W-1:0] MaxPos = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MinNeg = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] One    = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e          r_state, w_state_d;
    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic [PW-1:0]   r_acc, w_acc_d;
    logic [PW-1:0]   r_mcand, w_mcand_d;
    logic [W-1:0]    r_mplier, w_mplier_d;
    logic            r_neg, w_neg_d;
    logic [W-1:0]    r_res, w_res_d;
    logic            r_ovf, w_ovf_d;
    logic            r_done, w_done_d;

    // Add/sub path: subtraction is a + ~b + 1.
    logic [W-1:0] w_b_eff;
    logic [W-1:0] w_sum;
    logic         w_as_ovf;
    logic [W-1:0] w_as_res;

    assign w_b_eff  = bus.control_sig[0] ? ~bus.b : bus.b;
    assign w_sum    = bus.a + w_b_eff + (bus.control_sig[0] ? One : '0);
    assign w_as_ovf = (bus.a[W-1] == w_b_eff[W-1]) && (w_sum[W-1] != bus.a[W-1]);

    // An overflowed sum always has the true sign of a.
`ifdef AS_MUL_SATURATE_EN
    assign w_as_res = w_as_ovf ? (bus.a[W-1] ? MinNeg : MaxPos) : w_sum;
`else
    assign w_as_res = w_sum;
`endif

    // Operand magnitudes; the most-negative value maps to the unsigned MinNeg pattern.
    logic [W-1:0] w_mag_a;
    logic [W-1:0] w_mag_b;

    assign w_mag_a = bus.a[W-1] ? (~bus.a + One) : bus.a;
    assign w_mag_b = bus.b[W-1] ? (~bus.b + One) : bus.b;

    // Multiply path: w_prod is the accumulator after the current iteration, so on the
    // final iteration it is the full magnitude product.
    logic [PW-1:0]             w_prod;
    logic [W-1:0]              w_kept;
    logic [PW-3*PART_LEN-1:0]  w_high;
    logic                      w_mul_ovf;
    logic [W-1:0]              w_mul_res;

    assign w_prod = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_kept = W'(w_prod >> PART_LEN);
    assign w_high = w_prod[PW-1:3*PART_LEN];

    // Negative results may reach magnitude MinNeg; positive ones must stay below it.
    assign w_mul_ovf = (|w_high) || (r_neg ? (w_kept > MinNeg) : w_kept[W-1]);

`ifdef AS_MUL_SATURATE_EN
    assign w_mul_res = w_mul_ovf ? (r_neg ? MinNeg : MaxPos)
                                 : (r_neg ? (~w_kept + One) : w_kept);
`else
    assign w_mul_res = r_neg ? (~w_kept + One) : w_kept;
`endif

    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_acc_d    = r_acc;
        w_mcand_d  = r_mcand;
        w_mplier_d = r_mplier;
        w_neg_d    = r_neg;
        w_res_d    = r_res;
        w_ovf_d    = r_ovf;
        w_done_d   = 1'b0;

        case (r_state)
            StIdle: begin
                if (bus.start) begin
                    if (bus.control_sig[1]) begin
                        w_res_d  = w_as_res;
                        w_ovf_d  = w_as_ovf;
                        w_done_d = 1'b1;
                    end else begin
                        w_state_d  = StMul;
                        w_cnt_d    = '0;
                        w_acc_d    = '0;
                        w_mcand_d  = {{(PW-W){1'b0}}, w_mag_a};
                        w_mplier_d = w_mag_b;
                        w_neg_d    = bus.a[W-1] ^ bus.b[W-1];
                    end
                end
            end
            StMul: begin
                w_acc_d    = w_prod;
                w_mcand_d  = r_mcand << 1;
                w_mplier_d = r_mplier >> 1;
                w_cnt_d    = r_cnt + CntW'(1);
                if (r_cnt == CntW'(W - 1)) begin
                    w_state_d = StIdle;
                    w_res_d   = w_mul_res;
                    w_ovf_d   = w_mul_ovf;
                    w_done_d  = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_res    <= '0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_acc    <= w_acc_d;
            r_mcand  <= w_mcand_d;
            r_mplier <= w_mplier_d;
            r_neg    <= w_neg_d;
            r_res    <= w_res_d;
            r_ovf    <= w_ovf_d;
            r_done   <= w_done_d;
        end
    end

    assign bus.res  = r_res;
    assign bus.ovf  = r_ovf;
    assign bus.done = r_done;
    assign bus.busy = (r_state == StMul);
endmodule

// File: tb/tb_as_mul_c.sv
// tb_as_mul_c: self-checking bench for as_mul_c with PART_LEN=8.
// Directed vector table, hand-written reset/ignore/hold sequences, and random operations
// compared against an integer-arithmetic reference model.
module tb_as_mul_c;
    localparam int unsigned PL = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    as_mul_c_if #(.PART_LEN(PL)) bus ();

    as_mul_c #(.PART_LEN(PL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  ctl;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic        o;
        int          poke;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact integer arithmetic, then range check and wrap/clamp.
    function automatic void model(input logic [1:0] ctl, input logic [15:0] a,
                                  input logic [15:0] b, output logic [15:0] r,
                                  output logic o);
        longint      sa, sb, p, m, v;
        logic [63:0] vb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (ctl[1]) begin
            v = ctl[0] ? (sa - sb) : (sa + sb);
        end else begin
            p = sa * sb;
            m = (p < 0) ? -p : p;
            m = m / 256;
            v = (p < 0) ? -m : m;
        end
        o  = (v > 32767) || (v < -32768);
        vb = v;
        r  = vb[15:0];
`ifdef AS_MUL_SATURATE_EN
        if (o) r = (v > 0) ? 16'h7FFF : 16'h8000;
`endif
    endfunction

    // Issue one operation from a post-edge point; returns in the done cycle so a
    // following call starts in that same cycle. poke>0 pulses a stray start then.
    task automatic exec(input string name, input logic [1:0] ctl, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_r, input logic exp_o,
                        input int poke);
        int lat;
        int bcnt;
        int exp_lat;
        int exp_bcnt;
        exp_lat  = ctl[1] ? 1 : 2 * PL + 1;
        exp_bcnt = ctl[1] ? 0 : 2 * PL;
        bus.start       = 1'b1;
        bus.control_sig = ctl;
        bus.a           = a;
        bus.b           = b;
        step();
        bus.start       = 1'b0;
        bus.a           = 16'($urandom);
        bus.b           = 16'($urandom);
        bus.control_sig = 2'($urandom);
        lat  = 1;
        bcnt = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) bcnt++;
            bus.start = (lat == poke);
            step();
            lat++;
        end
        bus.start = 1'b0;
        check({name, " latency"}, lat, exp_lat);
        check({name, " busy_cycles"}, bcnt, exp_bcnt);
        check({name, " busy_at_done"}, bus.busy, 1'b0);
        check({name, " res"}, bus.res, exp_r);
        check({name, " ovf"}, bus.ovf, exp_o);
    endtask

    task automatic watch_no_done(input string name, input int cycles);
        int n;
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (bus.done === 1'b1) n++;
        end
        check({name, " stray_done"}, n, 0);
    endtask

    function automatic logic [15:0] pick_operand();
        logic [15:0] corners[6];
        corners[0] = 16'h8000;
        corners[1] = 16'h7FFF;
        corners[2] = 16'h0000;
        corners[3] = 16'hFFFF;
        corners[4] = 16'h0100;
        corners[5] = 16'hFF00;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return 16'($urandom);
    endfunction

    initial begin
        vecs[0] = '{2'b10, 16'h0180, 16'h0240, 16'h03C0, 1'b0, 0};
        vecs[1] = '{2'b11, 16'h0180, 16'h0240, 16'hFF40, 1'b0, 0};
        vecs[2] = '{2'b00, 16'h0180, 16'h0240, 16'h0360, 1'b0, 0};
        vecs[3] = '{2'b00, 16'hFE80, 16'h0240, 16'hFCA0, 1'b0, 5};
        vecs[8] = '{2'b00, 16'h8000, 16'h0100, 16'h8000, 1'b0, 0};
        vecs[9] = '{2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 0};
`ifdef AS_MUL_SATURATE_EN
        vecs[4] = '{2'b10, 16'h7F00, 16'h0200, 16'h7FFF, 1'b1, 0};
        vecs[5] = '{2'b00, 16'h4000, 16'h0400, 16'h7FFF, 1'b1, 0};
        vecs[6] = '{2'b00, 16'h8000, 16'h8000, 16'h7FFF, 1'b1, 0};
        vecs[7] = '{2'b11, 16'h0000, 16'h8000, 16'h7FFF, 1'b1, 0};
`else
        vecs[4] = '{2'b10, 16'h7F00, 16'h0200, 16'h8100, 1'b1, 0};
        vecs[5] = '{2'b00, 16'h4000, 16'h0400, 16'h0000, 1'b1, 0};
        vecs[6] = '{2'b00, 16'h8000, 16'h8000, 16'h0000, 1'b1, 0};
        vecs[7] = '{2'b11, 16'h0000, 16'h8000, 16'h8000, 1'b1, 0};
`endif

        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.control_sig = 2'b00;
        bus.a           = '0;
        bus.b           = '0;
        repeat (3) step();
        rst = 1'b0;
        check("reset res", bus.res, 16'h0000);
        check("reset ovf", bus.ovf, 1'b0);
        check("reset busy", bus.busy, 1'b0);
        check("reset done", bus.done, 1'b0);

        // Directed table; consecutive entries also start in the previous done cycle.
        foreach (vecs[i]) begin
            exec($sformatf("vec%0d", i), vecs[i].ctl, vecs[i].a, vecs[i].b,
                 vecs[i].r, vecs[i].o, vecs[i].poke);
        end
        watch_no_done("after_table", 20);

        // Result holds while idle with changing inputs.
        exec("hold_op", 2'b10, 16'h0100, 16'h0100, 16'h0200, 1'b0, 0);
        repeat (6) begin
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
            bus.control_sig = 2'($urandom);
            step();
        end
        check("hold res", bus.res, 16'h0200);
        check("hold ovf", bus.ovf, 1'b0);

        // Reset mid-multiply after leaving res/ovf nonzero.
        exec("pre_reset", vecs[4].ctl, vecs[4].a, vecs[4].b, vecs[4].r, vecs[4].o, 0);
        bus.start       = 1'b1;
        bus.control_sig = 2'b00;
        bus.a           = 16'h0180;
        bus.b           = 16'h0240;
        step();
        bus.start = 1'b0;
        repeat (4) step();
        check("midmul busy_before_rst", bus.busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst busy", bus.busy, 1'b0);
        check("midrst res", bus.res, 16'h0000);
        check("midrst ovf", bus.ovf, 1'b0);
        check("midrst done", bus.done, 1'b0);
        watch_no_done("midrst", 30);

        // Start coinciding with reset is dropped.
        rst             = 1'b1;
        bus.start       = 1'b1;
        bus.control_sig = 2'b00;
        bus.a           = 16'h0100;
        bus.b           = 16'h0100;
        step();
        rst       = 1'b0;
        bus.start = 1'b0;
        check("rst_start busy", bus.busy, 1'b0);
        watch_no_done("rst_start", 20);

        // Random operations against the reference model.
        for (int i = 0; i < 150; i++) begin
            logic [1:0]  ctl;
            logic [15:0] ra, rb, er;
            logic        eo;
            ctl = 2'($urandom_range(0, 3));
            ra  = pick_operand();
            rb  = pick_operand();
            model(ctl, ra, rb, er, eo);
            exec($sformatf("rnd%0d ctl=%0b a=%h b=%h", i, ctl, ra, rb), ctl, ra, rb, er, eo, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d",
                 checks, failures);
        $fatal(1);
    end
endmodule
